// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the shared iterative multiply/divide unit.
// Accepts start requests from main control, pulses the unit start lines,
// counts the fixed iteration latency, then strobes the Hi/Lo writeback.
// Divide-by-zero skips the divider and raises a one-cycle exception.
// Every output is a register, so no input reaches an output combinationally.
module muldiv_seq #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic divisor_zero,
  output logic mult_start,
  output logic div_start,
  output logic hilo_sel,
  output logic hi_write,
  output logic lo_write,
  output logic div_zero_exc,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MRUN = 3'd1,
    DRUN = 3'd2,
    WB   = 3'd3,
    EXC  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] multLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] divLoad  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] iterCnt;

  // State, iteration counter and all registered outputs advance together.
  // Pulse outputs default low each cycle; busy and hilo_sel are held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      iterCnt      <= '0;
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      hilo_sel     <= 1'b0;
      hi_write     <= 1'b0;
      lo_write     <= 1'b0;
      div_zero_exc <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      hi_write     <= 1'b0;
      lo_write     <= 1'b0;
      div_zero_exc <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          // Multiply has priority; a simultaneous divide request is dropped.
          if (start_mult) begin
            state      <= MRUN;
            iterCnt    <= multLoad;
            mult_start <= 1'b1;
            hilo_sel   <= 1'b0;
            busy       <= 1'b1;
          end else if (start_div) begin
            busy <= 1'b1;
            if (divisor_zero) begin
              state        <= EXC;
              div_zero_exc <= 1'b1;
            end else begin
              state     <= DRUN;
              iterCnt   <= divLoad;
              div_start <= 1'b1;
              hilo_sel  <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        MRUN, DRUN: begin
          // Counter hitting zero always exits, so it can never wrap.
          if (iterCnt == '0) begin
            state    <= WB;
            hi_write <= 1'b1;
            lo_write <= 1'b1;
            done     <= 1'b1;
          end else begin
            iterCnt <= iterCnt - 1'b1;
          end
        end
        WB, EXC: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with default parameters (32-cycle runs).
// Table entries run back to back: each op starts in the IDLE cycle that
// follows the previous op, exercising the minimum accepted gap.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic reset, start_mult, start_div, divisor_zero;
  logic mult_start, div_start, hilo_sel, hi_write, lo_write;
  logic div_zero_exc, busy, done;

  int passCnt = 0;
  int totalCnt = 0;

  muldiv_seq #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div), .divisor_zero(divisor_zero),
    .mult_start(mult_start), .div_start(div_start), .hilo_sel(hilo_sel),
    .hi_write(hi_write), .lo_write(lo_write), .div_zero_exc(div_zero_exc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {mult_start, div_start, hilo_sel, hi_write, lo_write, div_zero_exc, busy, done}
  logic [7:0] outVec;
  assign outVec = {mult_start, div_start, hilo_sel, hi_write, lo_write,
                   div_zero_exc, busy, done};

  typedef struct {
    logic       sm, sd, dz;
    logic [1:0] expStart;  // {mult_start, div_start} in first busy cycle
    int         runLen;    // busy cycles
    logic       expSel;
    logic       expWb;
    logic       expExc;
    int         lateAt;    // cycle to inject an ignored start_div (0 = none)
    string      name;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int cyc, input logic [7:0] got,
                       input logic [7:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s cyc%0d: got %b want %b", name, cyc, got, exp);
  endtask

  // Apply one op in the current (IDLE) cycle and check every following cycle,
  // stopping in the IDLE cycle after WB/EXC without stepping past it.
  task automatic runOp(input vec_t v);
    start_mult = v.sm; start_div = v.sd; divisor_zero = v.dz;
    step();
    start_mult = 0; start_div = 0; divisor_zero = 0;
    for (int k = 1; k <= v.runLen + 1; k++) begin
      logic [7:0] e;
      logic wb, ex;
      wb = v.expWb && (k == v.runLen);
      ex = v.expExc && (k == v.runLen);
      e = {(k == 1) ? v.expStart : 2'b00, v.expSel, wb, wb, ex,
           logic'(k <= v.runLen), wb};
      check(v.name, k, outVec, e);
      if (k <= v.runLen) begin
        if (k == v.lateAt) begin
          start_div = 1; divisor_zero = 0;
        end
        step();
        start_div = 0;
      end
    end
  endtask

  initial begin
    //        sm sd dz start  len sel wb exc late name
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b10, 33, 1'b0, 1'b1, 1'b0, 0,  "mult"};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 2'b01, 33, 1'b1, 1'b1, 1'b0, 0,  "div"};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2'b00, 1,  1'b1, 1'b0, 1'b1, 0,  "divzero_selhold1"};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b10, 33, 1'b0, 1'b1, 1'b0, 10, "both_late_div"};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2'b00, 1,  1'b0, 1'b0, 1'b1, 0,  "divzero_selhold0"};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 2'b10, 33, 1'b0, 1'b1, 1'b0, 0,  "both_dz_multwins"};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 2'b01, 33, 1'b1, 1'b1, 1'b0, 0,  "div2"};

    reset = 1; start_mult = 0; start_div = 0; divisor_zero = 0;
    step(); step();
    check("in_reset", 0, outVec, 8'h00);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      check("idle_after_reset", i, outVec, 8'h00);
      step();
    end

    for (int i = 0; i < 7; i++) runOp(vecs[i]);

    // Reset in the middle of a multiply aborts it with no writeback.
    start_mult = 1;
    step();
    start_mult = 0;
    for (int k = 1; k <= 15; k++) begin
      check("mult_pre_reset", k, outVec, (k == 1) ? 8'b1000_0010 : 8'b0000_0010);
      if (k == 15) reset = 1;
      step();
    end
    reset = 0;
    check("mult_reset_abort", 16, outVec, 8'h00);
    step();
    check("after_abort_idle", 17, outVec, 8'h00);
    runOp(vecs[1]);
    runOp(vecs[2]);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
